// File: rtl/cselsub_serial_if.sv
// Handshake and operand/result bundle for cselsub_serial.
// The ovf signal exists only when CSELSUB_OVF_EN is defined.
interface cselsub_serial_if #(
  parameter int unsigned SIZE = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            bin;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] diff;
  logic            bout;
  logic            busy;
`ifdef CSELSUB_OVF_EN
  logic            ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, busy, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, busy
  );
`endif
endinterface

// File: rtl/cselsub_serial.sv
// Multi-cycle borrow-select subtractor: diff = a - b - bin, GPC 4-bit groups per clock.
// Optional signed-overflow output enabled by defining CSELSUB_OVF_EN.
module cselsub_serial #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned GPC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  cselsub_serial_if.slave io
);

  localparam int unsigned G  = SIZE / (4 * GPC);
  localparam int unsigned CW = (G > 1) ? $clog2(G) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((SIZE < 4) || ((SIZE % 4) != 0) || (GPC == 0) || (((SIZE / 4) % GPC) != 0)) begin : g_bad_cfg
    $error("cselsub_serial: SIZE must be a multiple of 4 and GPC must divide SIZE/4");
  end

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [SIZE-1:0] diff_q, diff_d;
  logic            brw_q, brw_d;
  logic            bout_q, bout_d;
`ifdef CSELSUB_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic            last_c;
  logic            brw_c;
  logic [4:0]      d0_c, d1_c;
  int unsigned     base_c;

  // Next-state, group select and borrow chain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
`ifdef CSELSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    last_c  = (cnt_q == CW'(G - 1));
    brw_c   = brw_q;
    d0_c    = '0;
    d1_c    = '0;
    base_c  = 0;

    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          a_d     = io.a;
          b_d     = io.b;
          brw_d   = io.bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Both candidates per group; incoming borrow picks one and chains on.
        for (int unsigned j = 0; j < GPC; j++) begin
          base_c = ((32'(cnt_q) * GPC) + j) * 4;
          d0_c   = {1'b0, a_q[base_c +: 4]} - {1'b0, b_q[base_c +: 4]};
          d1_c   = {1'b0, a_q[base_c +: 4]} - {1'b0, b_q[base_c +: 4]} - 5'd1;
          diff_d[base_c +: 4] = brw_c ? d1_c[3:0] : d0_c[3:0];
          brw_c  = brw_c ? d1_c[4] : d0_c[4];
        end
        brw_d = brw_c;
        if (last_c) begin
          bout_d  = brw_c;
`ifdef CSELSUB_OVF_EN
          ovf_d   = (a_q[SIZE-1] != b_q[SIZE-1]) & (diff_d[SIZE-1] != a_q[SIZE-1]);
`endif
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (io.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef CSELSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
`ifdef CSELSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake flags are pure state decodes; results come straight from flops.
  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign io.diff      = diff_q;
  assign io.bout      = bout_q;
`ifdef CSELSUB_OVF_EN
  assign io.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cselsub_serial.sv
// Self-checking bench for cselsub_serial: GPC=1 and GPC=4 instances side by side.
// Checks ovf as well when CSELSUB_OVF_EN is defined.
module tb_cselsub_serial;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cselsub_serial_if #(.SIZE(16)) io1 ();
  cselsub_serial_if #(.SIZE(16)) io4 ();

  cselsub_serial #(.SIZE(16), .GPC(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(io1));
  cselsub_serial #(.SIZE(16), .GPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(io4));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_out_ready(input string tag);
    @(negedge clk);
    io1.out_ready = 1'b1;
    io4.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " in_ready1 after take"}, 32'(io1.in_ready), 32'd1);
    chk({tag, " out_valid1 after take"}, 32'(io1.out_valid), 32'd0);
    chk({tag, " in_ready4 after take"}, 32'(io4.in_ready), 32'd1);
    io1.out_ready = 1'b0;
    io4.out_ready = 1'b0;
  endtask

  // One operand set through both instances; latency, result and hold checked.
  task automatic do_vec(input vec_t v, input string tag);
    int lat1, lat4, busy_lo;
    @(negedge clk);
    io1.a = v.a; io1.b = v.b; io1.bin = v.bin; io1.in_valid = 1'b1;
    io4.a = v.a; io4.b = v.b; io4.bin = v.bin; io4.in_valid = 1'b1;
    @(posedge clk); #1;
    io1.in_valid = 1'b0; io4.in_valid = 1'b0;
    io1.a = 16'h5A5A; io1.b = 16'hC3C3; io1.bin = ~v.bin;
    io4.a = 16'h5A5A; io4.b = 16'hC3C3; io4.bin = ~v.bin;
    lat1 = 0; lat4 = 0; busy_lo = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (lat1 == 0 && io1.out_valid) lat1 = cyc;
      if (lat4 == 0 && io4.out_valid) lat4 = cyc;
      if (!io1.busy || !io4.busy) busy_lo++;
    end
    chk({tag, " latency gpc1"}, 32'(lat1), 32'd4);
    chk({tag, " latency gpc4"}, 32'(lat4), 32'd1);
    chk({tag, " busy low cycles"}, 32'(busy_lo), 32'd0);
    chk({tag, " diff gpc1"}, 32'(io1.diff), 32'(v.diff));
    chk({tag, " bout gpc1"}, 32'(io1.bout), 32'(v.bout));
    chk({tag, " diff gpc4"}, 32'(io4.diff), 32'(v.diff));
    chk({tag, " bout gpc4"}, 32'(io4.bout), 32'(v.bout));
    chk({tag, " in_ready1 in done"}, 32'(io1.in_ready), 32'd0);
`ifdef CSELSUB_OVF_EN
    chk({tag, " ovf gpc1"}, 32'(io1.ovf), 32'(v.ovf));
    chk({tag, " ovf gpc4"}, 32'(io4.ovf), 32'(v.ovf));
`endif
    pulse_out_ready(tag);
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (!io1.out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
    vecs[6] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

    io1.in_valid = 1'b0; io1.a = '0; io1.b = '0; io1.bin = 1'b0; io1.out_ready = 1'b0;
    io4.in_valid = 1'b0; io4.a = '0; io4.b = '0; io4.bin = 1'b0; io4.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset in_ready", 32'(io1.in_ready), 32'd1);
    chk("reset out_valid", 32'(io1.out_valid), 32'd0);
    chk("reset busy", 32'(io1.busy), 32'd0);
    chk("reset diff", 32'(io1.diff), 32'd0);
    chk("reset bout", 32'(io1.bout), 32'd0);
    chk("reset diff gpc4", 32'(io4.diff), 32'd0);
`ifdef CSELSUB_OVF_EN
    chk("reset ovf", 32'(io1.ovf), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Mid-run reset: bout is 1 and diff nonzero going in, both must clear at once.
    @(negedge clk);
    io1.a = 16'hABCD; io1.b = 16'h1234; io1.bin = 1'b1; io1.in_valid = 1'b1;
    @(posedge clk); #1;
    io1.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(io1.in_ready), 32'd1);
    chk("midrst out_valid", 32'(io1.out_valid), 32'd0);
    chk("midrst busy", 32'(io1.busy), 32'd0);
    chk("midrst diff", 32'(io1.diff), 32'd0);
    chk("midrst bout", 32'(io1.bout), 32'd0);
    chk("midrst diff gpc4", 32'(io4.diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_vec('{16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0}, "postrst");

    // Backpressure in DONE with new operands already waiting.
    @(negedge clk);
    io1.a = 16'h0005; io1.b = 16'h0003; io1.bin = 1'b0; io1.in_valid = 1'b1;
    @(posedge clk); #1;
    io1.in_valid = 1'b0;
    wait_done1(n);
    chk("bp first latency", 32'(n), 32'd4);
    chk("bp first diff", 32'(io1.diff), 32'h0002);
    io1.a = 16'h1111; io1.b = 16'h0011; io1.bin = 1'b0; io1.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d out_valid", k), 32'(io1.out_valid), 32'd1);
      chk($sformatf("bp hold%0d in_ready", k), 32'(io1.in_ready), 32'd0);
      chk($sformatf("bp hold%0d diff", k), 32'(io1.diff), 32'h0002);
      chk($sformatf("bp hold%0d bout", k), 32'(io1.bout), 32'd0);
    end
    @(negedge clk);
    io1.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", 32'(io1.in_ready), 32'd1);
    chk("bp release out_valid", 32'(io1.out_valid), 32'd0);
    io1.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp queued accepted in_ready", 32'(io1.in_ready), 32'd0);
    chk("bp queued accepted busy", 32'(io1.busy), 32'd1);
    io1.in_valid = 1'b0;
    wait_done1(n);
    chk("bp second latency", 32'(n), 32'd4);
    chk("bp second diff", 32'(io1.diff), 32'h1100);
    chk("bp second bout", 32'(io1.bout), 32'd0);
    pulse_out_ready("bp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
